// File: rtl/one_hot_rr_dispatch.sv
// Round-robin dispatcher: each accepted upstream beat lands in the first free
// one-entry port register found by searching circularly from the round pointer.
module one_hot_rr_dispatch #(
    parameter  int N_OUTPUT       = 4,
    parameter  int DATA_WIDTH     = 32,
    localparam int N_OUTPUT_WIDTH = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_vld_i,
    output logic                           in_rdy_o,
    input  logic [DATA_WIDTH-1:0]          in_data_i,
    output logic [N_OUTPUT-1:0]            out_vld_o,
    input  logic [N_OUTPUT-1:0]            out_rdy_i,
    output logic [N_OUTPUT*DATA_WIDTH-1:0] out_data_o,
    output logic [N_OUTPUT-1:0]            sel_oh_o,
    output logic [N_OUTPUT_WIDTH-1:0]      sel_idx_o
);

    logic                      r_vld  [N_OUTPUT];
    logic [DATA_WIDTH-1:0]     r_data [N_OUTPUT];
    logic [N_OUTPUT_WIDTH-1:0] r_ptr;

    logic [N_OUTPUT-1:0]       w_free;
    logic [N_OUTPUT-1:0]       w_hi_mask;
    logic [N_OUTPUT-1:0]       w_req_hi;
    logic [N_OUTPUT-1:0]       w_req;
    logic [N_OUTPUT-1:0]       w_sel_oh;
    logic [N_OUTPUT_WIDTH-1:0] w_idx_acc [N_OUTPUT+1];
    logic [N_OUTPUT_WIDTH-1:0] w_sel_idx;
    logic [N_OUTPUT_WIDTH-1:0] w_ptr_next;
    logic                      w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUTPUT; gi++) begin : g_port
            logic w_load;

            assign w_free[gi]    = ~r_vld[gi] | out_rdy_i[gi];
            assign w_hi_mask[gi] = (N_OUTPUT_WIDTH'(gi) >= r_ptr);
            assign w_idx_acc[gi+1] = w_idx_acc[gi] |
                                     (w_sel_oh[gi] ? N_OUTPUT_WIDTH'(gi) : '0);
            assign w_load        = w_xfer & w_sel_oh[gi];

            // A load wins over a drain so a same-cycle drain+reload stays valid.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_vld[gi]  <= 1'b0;
                    r_data[gi] <= '0;
                end else if (w_load) begin
                    r_vld[gi]  <= 1'b1;
                    r_data[gi] <= in_data_i;
                end else if (out_rdy_i[gi]) begin
                    r_vld[gi]  <= 1'b0;
                end
            end

            assign out_vld_o[gi] = r_vld[gi];
            assign out_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_data[gi];
        end
    endgenerate

    // Prefer free ports at or above the pointer; otherwise wrap to the lowest free one.
    assign w_req_hi     = w_free & w_hi_mask;
    assign w_req        = (|w_req_hi) ? w_req_hi : w_free;
    assign w_sel_oh     = w_req & (~w_req + N_OUTPUT'(1));
    assign w_idx_acc[0] = '0;
    assign w_sel_idx    = w_idx_acc[N_OUTPUT];

    assign w_xfer     = in_vld_i & in_rdy_o;
    assign w_ptr_next = (w_sel_idx == N_OUTPUT_WIDTH'(N_OUTPUT - 1)) ? '0
                                                                     : w_sel_idx + N_OUTPUT_WIDTH'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign in_rdy_o  = |w_free;
    assign sel_oh_o  = w_sel_oh;
    assign sel_idx_o = w_sel_idx;

endmodule

// File: doc/one_hot_rr_dispatch.md
ONE_HOT_RR_DISPATCH -- requirements
Module: one_hot_rr_dispatch

Interface
REQ-001: Parameter N_OUTPUT, default 4, number of downstream ports; legal range 1..16.
REQ-002: Parameter DATA_WIDTH, default 32, payload width in bits.
REQ-003: Derived N_OUTPUT_WIDTH = N_OUTPUT>1 ? clog2(N_OUTPUT) : 1; it is fixed by the parameters and cannot be overridden.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rstn  input  1  reset, asynchronous assert, active-low.
REQ-006: in_vld_i  input  1  upstream payload valid.
REQ-007: in_rdy_o  output  1  upstream ready; a transfer occurs when in_vld_i & in_rdy_o.
REQ-008: in_data_i  input  DATA_WIDTH  upstream payload.
REQ-009: out_vld_o  output  N_OUTPUT  per-port valid, one bit per port.
REQ-010: out_rdy_i  input  N_OUTPUT  per-port ready.
REQ-011: out_data_o  output  N_OUTPUT*DATA_WIDTH  per-port payload; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012: sel_oh_o  output  N_OUTPUT  one-hot port targeted this cycle; all zero when no port is free.
REQ-013: sel_idx_o  output  N_OUTPUT_WIDTH  binary index of sel_oh_o; 0 when sel_oh_o is zero.

Function
REQ-014: Each port SHALL own a one-entry output register: a valid flag vld_q[k] and a data register data_q[k]; out_vld_o[k]=vld_q[k] and out_data_o slice k=data_q[k].
REQ-015: A port SHALL be free in a cycle when ~vld_q[k] | out_rdy_i[k], meaning it is empty or drains this cycle.
REQ-016: The round pointer ptr_q SHALL range over 0..N_OUTPUT-1.
REQ-017: sel_oh_o SHALL select the first free port found by searching circularly upward from ptr_q (ptr_q, ptr_q+1, ..., N_OUTPUT-1, 0, ...); this logic is combinational.
REQ-018: in_rdy_o SHALL equal the OR of all free bits; it depends combinationally on out_rdy_i and not on in_vld_i.
REQ-019: On an upstream transfer, the selected port k SHALL load data_q[k]<=in_data_i and set vld_q[k]<=1 at the next edge, giving one cycle of latency from input to output.
REQ-020: On an upstream transfer, ptr_q SHALL update to sel_idx_o+1, wrapping from N_OUTPUT-1 to 0; the wrap SHALL be correct for non-power-of-2 N_OUTPUT.
REQ-021: Without an upstream transfer, ptr_q SHALL hold; a cycle with in_vld_i=0 or in_rdy_o=0 does not advance it.
REQ-022: Port k SHALL clear vld_q[k] on out_vld_o[k]&out_rdy_i[k] unless it is reloaded in the same cycle; simultaneous drain and load keeps vld_q[k]=1 with the new data.
REQ-023: data_q[k] SHALL change only on a load; out_data_o of a port that is valid and stalled SHALL stay stable.
REQ-024: Ports that are not selected SHALL be unaffected by an upstream transfer.
REQ-025: No payload is dropped or duplicated; each accepted beat SHALL appear exactly once on exactly one port.
REQ-026: When N_OUTPUT=1: sel_idx_o=0, ptr_q is constant 0, and behaviour reduces to a single pipeline register with in_rdy_o=~vld_q[0]|out_rdy_i[0].
REQ-027: Behaviour is undefined if in_data_i changes while in_vld_i=1 and in_rdy_o=0; the block need not check this.

Reset
REQ-028: While rstn=0: vld_q all 0, ptr_q=0, out_vld_o=0; data_q SHALL reset to 0.
REQ-029: Reset asserted mid-operation SHALL discard all buffered beats immediately (asynchronously); after release, the first transfer SHALL go to port 0.
REQ-030: Immediately after reset, in_rdy_o=1 and sel_oh_o=0001 (for N_OUTPUT=4).

Verification (N_OUTPUT=4, DATA_WIDTH=32)
REQ-031: out_rdy_i=1111, in_vld_i=1 for 8 cycles with data 0..7 -> port 0 gets 0 and 4, port 1 gets 1 and 5, port 2 gets 2 and 6, port 3 gets 3 and 7, each valid one cycle after acceptance.
REQ-032: out_rdy_i=0000, send 4 beats A,B,C,D -> they land on ports 0..3; in_rdy_o=0 on the 5th cycle; E is held off and data stays stable.
REQ-033: From the REQ-032 state, raise out_rdy_i=0100 with E pending -> in the same cycle port 2 drains C and loads E (vld stays 1), and ptr becomes 3.
REQ-034: ptr=1, vld_q=0010, out_rdy_i=0000, one beat -> it skips busy port 1, goes to port 2, and ptr becomes 3.
REQ-035: N_OUTPUT=3, 6 beats with all outputs ready -> ports are used in order 0,1,2,0,1,2 and ptr never reaches 3.
REQ-036: Assert rstn=0 asynchronously with vld_q=1011, then release and send one beat -> all valids clear at once, and the beat goes to port 0.
